// File: rtl/fifo_uart_tx.sv
// UART transmitter draining a FIFO: pops one word, sends start, DWIDTH data bits LSB-first, stop.
// Define FIFO_UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module fifo_uart_tx #(
    parameter int DWIDTH       = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              fifo_empty,
    input  logic [DWIDTH-1:0] fifo_data,
    output logic              fifo_rd,
    output logic              txd,
    output logic              busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DWIDTH + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DWIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_POP    = 3'd1,
        S_LOAD   = 3'd2,
        S_START  = 3'd3,
        S_DATA   = 3'd4,
`ifdef FIFO_UART_TX_PARITY_EN
        S_PARITY = 3'd5,
`endif
        S_STOP   = 3'd6
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [CW-1:0]     r_cnt, w_cnt_nxt;
    logic [BW-1:0]     r_bit, w_bit_nxt;
    logic [DWIDTH-1:0] r_shift, w_shift_nxt;
    logic              r_txd, w_txd_nxt;
    logic              r_rd, w_rd_nxt;
    logic              w_wrap;
`ifdef FIFO_UART_TX_PARITY_EN
    logic              r_par, w_par_nxt;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_txd   <= 1'b1;
            r_rd    <= 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
            r_par   <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_bit   <= w_bit_nxt;
            r_shift <= w_shift_nxt;
            r_txd   <= w_txd_nxt;
            r_rd    <= w_rd_nxt;
`ifdef FIFO_UART_TX_PARITY_EN
            r_par   <= w_par_nxt;
`endif
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        w_txd_nxt   = r_txd;
        w_rd_nxt    = 1'b0;
        w_wrap      = (r_cnt == CNT_LAST);
`ifdef FIFO_UART_TX_PARITY_EN
        w_par_nxt   = r_par;
`endif
        case (r_state)
            S_IDLE: begin
                w_txd_nxt = 1'b1;
                if (en && !fifo_empty) begin
                    w_rd_nxt    = 1'b1;
                    w_state_nxt = S_POP;
                end
            end
            // FIFO presents the popped word at the edge closing this state
            S_POP: w_state_nxt = S_LOAD;
            S_LOAD: begin
                w_shift_nxt = fifo_data;
                w_txd_nxt   = 1'b0;
                w_cnt_nxt   = '0;
                w_bit_nxt   = '0;
                w_state_nxt = S_START;
`ifdef FIFO_UART_TX_PARITY_EN
                w_par_nxt   = ^fifo_data;
`endif
            end
            S_START: begin
                if (w_wrap) begin
                    w_cnt_nxt   = '0;
                    w_txd_nxt   = r_shift[0];
                    w_state_nxt = S_DATA;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_DATA: begin
                if (w_wrap) begin
                    w_cnt_nxt = '0;
                    if (r_bit == BIT_LAST) begin
`ifdef FIFO_UART_TX_PARITY_EN
                        w_txd_nxt   = r_par;
                        w_state_nxt = S_PARITY;
`else
                        w_txd_nxt   = 1'b1;
                        w_state_nxt = S_STOP;
`endif
                    end else begin
                        w_bit_nxt   = r_bit + 1'b1;
                        w_shift_nxt = r_shift >> 1;
                        w_txd_nxt   = w_shift_nxt[0];
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
`ifdef FIFO_UART_TX_PARITY_EN
            S_PARITY: begin
                if (w_wrap) begin
                    w_cnt_nxt   = '0;
                    w_txd_nxt   = 1'b1;
                    w_state_nxt = S_STOP;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
`endif
            S_STOP: begin
                if (w_wrap) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_txd_nxt   = 1'b1;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign fifo_rd = r_rd;
    assign txd     = r_txd;
    assign busy    = (r_state != S_IDLE);

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: behavioural FIFO, table vectors, random words checked against a frame model.
module tb_fifo_uart_tx;

    localparam int DW  = 8;
    localparam int CPB = 4;
`ifdef FIFO_UART_TX_PARITY_EN
    localparam int NB = DW + 3;
`else
    localparam int NB = DW + 2;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en;
    logic          fifo_empty;
    logic [DW-1:0] fifo_data = '0;
    logic          fifo_rd;
    logic          txd;
    logic          busy;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    logic [DW-1:0] mem [0:255];
    int n_pushed = 0;
    int n_popped = 0;
    int rd_empty = 0;

    fifo_uart_tx #(.DWIDTH(DW), .CLKS_PER_BIT(CPB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .fifo_empty(fifo_empty),
        .fifo_data (fifo_data),
        .fifo_rd   (fifo_rd),
        .txd       (txd),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Read side of the team FIFO: dataOut registers on the edge that samples rd.
    assign fifo_empty = (n_pushed == n_popped);
    always @(posedge clk) begin
        if (fifo_rd) begin
            if (n_pushed != n_popped) begin
                fifo_data <= mem[n_popped];
                n_popped  <= n_popped + 1;
            end else begin
                rd_empty <= rd_empty + 1;
            end
        end
    end

    task automatic push(input logic [DW-1:0] w);
        mem[n_pushed] = w;
        n_pushed = n_pushed + 1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Expected line sequence, index 0 transmitted first.
    function automatic logic [10:0] model_frame(input logic [DW-1:0] w);
        logic [10:0] f;
        f = '1;
        f[0] = 1'b0;
        for (int i = 0; i < DW; i++) f[i+1] = ((int'(w) >> i) % 2) == 1;
`ifdef FIFO_UART_TX_PARITY_EN
        f[DW+1] = ($countones(w) % 2) == 1;
`endif
        return f;
    endfunction

    function automatic logic [10:0] table_frame(input logic [9:0] fr, input logic par);
`ifdef FIFO_UART_TX_PARITY_EN
        return {1'b1, par, fr[8:0]};
`else
        return {1'b0, fr};
`endif
    endfunction

    task automatic expect_frame(input logic [10:0] exp, input string name, input int drop_at,
                                output int t_start, output int waited);
        int bad;
        int extra;
        waited  = 0;
        t_start = -1;
        do begin
            @(negedge clk);
            waited++;
        end while (fifo_rd !== 1'b1 && waited < 200);
        if (fifo_rd !== 1'b1) begin
            check({name, "_rd_timeout"}, 0, 1);
            return;
        end
        @(negedge clk);
        check({name, "_rd_pulse"}, int'(fifo_rd), 0);
        @(negedge clk);
        t_start = cyc;
        bad   = 0;
        extra = 0;
        for (int i = 0; i < NB * CPB; i++) begin
            if (i > 0) @(negedge clk);
            if (txd !== exp[i / CPB]) bad++;
            if (fifo_rd !== 1'b0 || busy !== 1'b1) extra++;
            if (i == drop_at) en = 1'b0;
        end
        check({name, "_bit_errs"}, bad, 0);
        check({name, "_rd_busy_errs"}, extra, 0);
        @(negedge clk);
        check({name, "_busy_end"}, int'(busy), 0);
        check({name, "_txd_end"}, int'(txd), 1);
    endtask

    typedef struct {
        logic [DW-1:0] data;
        logic [9:0]    frame;
        logic          par;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int t1, t2, w, bad, rem;
        logic [DW-1:0] q[$];
        logic [DW-1:0] rw, rw2;

        vecs[0] = '{8'hA5, 10'h34A, 1'b0};
        vecs[1] = '{8'h01, 10'h202, 1'b1};
        vecs[2] = '{8'h00, 10'h200, 1'b0};
        vecs[3] = '{8'hFF, 10'h3FE, 1'b0};
        vecs[4] = '{8'h3C, 10'h278, 1'b0};
        vecs[5] = '{8'h80, 10'h300, 1'b1};

        rst_n = 1'b1;
        en    = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_txd", int'(txd), 1);
        check("reset_rd_busy", int'(fifo_rd) + int'(busy), 0);
        rst_n = 1'b1;
        bad = 0;
        repeat (50) begin
            @(negedge clk);
            if (txd !== 1'b1 || fifo_rd !== 1'b0 || busy !== 1'b0) bad++;
        end
        check("idle_empty", bad, 0);

        for (int i = 0; i < 6; i++) begin
            push(vecs[i].data);
            expect_frame(table_frame(vecs[i].frame, vecs[i].par), $sformatf("vec%0d", i), -1, t1, w);
        end

        @(negedge clk);
        push(8'h00);
        push(8'hFF);
        expect_frame(model_frame(8'h00), "b2b_0", -1, t1, w);
        expect_frame(model_frame(8'hFF), "b2b_1", -1, t2, w);
        check("b2b_spacing", t2 - t1, NB * CPB + 3);
        check("b2b_empty", int'(fifo_empty), 1);

        for (int r = 0; r < 4; r++) begin
            @(negedge clk);
            repeat ($urandom_range(1, 3)) begin
                rw = DW'($urandom);
                q.push_back(rw);
                push(rw);
            end
            while (q.size() > 0) begin
                rw = q.pop_front();
                expect_frame(model_frame(rw), $sformatf("rnd%0d_%02h", r, rw), -1, t1, w);
            end
        end

        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            rw = DW'($urandom);
            q.push_back(rw);
            push(rw);
        end
        rw = q.pop_front();
        expect_frame(model_frame(rw), "endrop_cur", 3 * CPB, t1, w);
        bad = 0;
        repeat (30) begin
            @(negedge clk);
            if (fifo_rd !== 1'b0 || busy !== 1'b0) bad++;
        end
        check("endrop_idle", bad, 0);
        rem = n_pushed - n_popped;
        check("endrop_remaining", rem, 2);
        en = 1'b1;
        while (q.size() > 0) begin
            rw = q.pop_front();
            expect_frame(model_frame(rw), "endrop_drain", -1, t1, w);
        end

        @(negedge clk);
        rw2 = DW'($urandom);
        push(8'h00);
        push(rw2);
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (fifo_rd !== 1'b1 && w < 200);
        check("rst_mid_rd_seen", int'(fifo_rd), 1);
        repeat (2 + 3 * CPB + 1) @(negedge clk);
        check("rst_mid_txd_before", int'(txd), 0);
        #1 rst_n = 1'b0;
        #1;
        check("rst_mid_txd_async", int'(txd), 1);
        check("rst_mid_busy_async", int'(busy), 0);
        check("rst_mid_rd_async", int'(fifo_rd), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        expect_frame(model_frame(rw2), "rst_next", -1, t1, w);
        check("rst_next_latency", w, 1);

        check("no_rd_on_empty", rd_empty, 0);
        check("final_empty", int'(fifo_empty), 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fifo_uart_tx.md
# fifo_uart_tx

- Serial transmitter that sits on the read side of the team's `fifo` block.
- Pops one word at a time using the FIFO's `rd`/`empty`/`dataOut` handshake.
- Serializes each word LSB-first as an asynchronous UART frame on `txd`: start bit, DWIDTH data bits, optional even parity, one stop bit.
- Pairs with a producer that fills the FIFO, and turns it into a byte-stream UART output.

## Interface
- DWIDTH, 8, data word width; must match the FIFO's DWIDTH.
- CLKS_PER_BIT, 16, clock cycles per serial bit; legal range ≥ 2.

- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  asynchronous, active-low reset; one clock domain only.
- en  input  1  transmit enable; sampled only in IDLE.
- fifo_empty  input  1  FIFO `empty` flag.
- fifo_data  input  DWIDTH  FIFO `dataOut`; valid the cycle after a `fifo_rd` pulse.
- fifo_rd  output  1  FIFO `rd` strobe, registered, exactly one cycle per word; FIFO `en` is tied high.
- txd  output  1  serial line, registered, idles high.
- busy  output  1  high whenever state ≠ IDLE.

## Operation
- States:
  - IDLE: `txd`=1. If `en && !fifo_empty`: set `fifo_rd`<=1, go to POP.
  - POP: `fifo_rd` is high this cycle, and the FIFO registers `dataOut` at the closing edge. Set `fifo_rd`<=0, go to LOAD.
  - LOAD: latch `fifo_data` into shift register; `txd`<=0; clear baud counter and bit index; go to START.
  - START: hold `txd`=0 for CLKS_PER_BIT cycles.
  - DATA: shift out DWIDTH bits, LSB first, each held CLKS_PER_BIT cycles.
  - PARITY: present only with the macro.
  - STOP: `txd`=1 for CLKS_PER_BIT cycles, then go to IDLE.
- Baud counter: width $clog2(CLKS_PER_BIT). It counts 0..CLKS_PER_BIT-1 and wraps, advancing the bit on the wrap.
- Bit index: width $clog2(DWIDTH+1).
- Reset (async, any state, mid-frame included):
  - state=IDLE, `txd`=1, `fifo_rd`=0, `busy`=0.
  - Counters and shift register are cleared.
  - A partially sent frame is abandoned; no resend.
- `en` deasserted mid-frame: the current frame completes, then the block stays in IDLE.
- `fifo_empty` is ignored outside IDLE. A pop is only issued when `!fifo_empty`, so reading an empty FIFO is impossible.
- Producer writes during a frame have no effect on that frame; the shift register holds a private copy.

## Timing
- Let E0 be the edge where IDLE samples `en && !fifo_empty`:
  - E0: `fifo_rd` rises.
  - E1: `fifo_rd` falls and FIFO data updates.
  - E2: `txd` falls (start bit).
- Frame length from E2: (DWIDTH+2)·CLKS_PER_BIT cycles, or (DWIDTH+3)·CLKS_PER_BIT with parity.
- STOP→IDLE occurs on the edge ending the stop bit. `busy` falls on that edge.
- Back-to-back words: the line is high for CLKS_PER_BIT+3 cycles between frames (stop bit, IDLE, POP, LOAD).
- Maximum `fifo_rd` rate: one pulse per frame, never on consecutive cycles.

## Configuration
- Macro: `FIFO_UART_TX_PARITY_EN`.
- Defined: a PARITY state follows DATA. It sends the even-parity bit (XOR of data bits) for CLKS_PER_BIT cycles before STOP.
- Undefined: no PARITY state; DATA goes directly to STOP.

## Test plan
- Reset, then idle: hold `rst_n`=0 for 3 cycles, release with FIFO empty and `en`=1 → `txd`=1, `fifo_rd`=0, `busy`=0 for 50 cycles.
- Single frame, CLKS_PER_BIT=4, DWIDTH=8, FIFO holds 0xA5:
  - Exactly one `fifo_rd` pulse.
  - `txd` from E2 is 0,1,0,1,0,0,1,0,1,1, each held 4 cycles.
  - `busy` falls 40 cycles after E2.
- Back-to-back: FIFO holds 0x00 then 0xFF → two frames separated by exactly 7 high cycles. Two `fifo_rd` pulses total, then the FIFO reports empty.
- Parity (macro defined): 0x01 → parity bit 1; 0xA5 → parity bit 0. Frame is 44 cycles.
- `en` dropped in mid-DATA with 3 words queued → current frame completes with correct bits, no further `fifo_rd`, and 2 words remain in the FIFO.
- `rst_n` pulsed low in mid-DATA → `txd`=1 asynchronously, before the next clock edge. On release with `en`=1 and a non-empty FIFO, the next word starts a clean frame per E0–E2 timing.
